uart_rx_byte: RTL

- Serial-to-parallel UART receiver, 8 data bits, LSB first, optional parity, 1 stop bit.
- Sits directly upstream of the 8-bit load register: drives its value bus from `data` and its load strobe from `load`.
- The register therefore captures exactly one byte per correctly framed character.
- Also reports framing and parity errors for the status logic.

---
 rtl/uart_rx_byte.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 / 8E1 / 8O1 UART receiver feeding an 8-bit load register.
// A two-flop synchronizer conditions the raw line. A single FSM then samples
// mid-bit and emits a registered one-cycle strobe per outcome: load for a good
// frame, frame_err for a low stop bit, parity_err for a parity mismatch.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       load,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4,
        BRK   = 3'd5
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic          par_ok_r;
    logic          sync1_r;
    logic          sync2_r;
    logic [7:0]    data_r;
    logic          load_r;
    logic          busy_r;
    logic          frame_err_r;
    logic          parity_err_r;
    logic          rx_s;

    // Checks the received parity bit against the data byte for the configured mode.
    function automatic logic parity_ok(input logic [7:0] d, input logic p, input int mode);
        logic x;
        x = (^d) ^ p;
        if (mode == 1) begin
            parity_ok = (x == 1'b0);
        end else if (mode == 2) begin
            parity_ok = (x == 1'b1);
        end else begin
            parity_ok = 1'b1;
        end
    endfunction

    assign rx_s       = sync2_r;
    assign data       = data_r;
    assign load       = load_r;
    assign busy       = busy_r;
    assign frame_err  = frame_err_r;
    assign parity_err = parity_err_r;

    // Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rx;
            sync2_r <= sync1_r;
        end
    end

    // Receive FSM: start qualification, mid-bit sampling, parity/stop checks, break wait.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'h00;
            par_ok_r     <= 1'b1;
            data_r       <= 8'h00;
            load_r       <= 1'b0;
            busy_r       <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            load_r       <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    if (rx_s == 1'b0) begin
                        state_r <= START;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                START: begin
                    if (cnt_r == HALF) begin
                        cnt_r <= '0;
                        if (rx_s == 1'b0) begin
                            state_r   <= DATA;
                            bit_idx_r <= 3'd0;
                            par_ok_r  <= 1'b1;
                        end else begin
                            // Start bit did not survive to mid-bit: treat as a glitch.
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_r == LAST) begin
                        cnt_r     <= '0;
                        shift_r   <= {rx_s, shift_r[7:1]};
                        bit_idx_r <= bit_idx_r + 3'd1;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= (PARITY != 0) ? PAR : STOP;
                        end else begin
                            state_r <= DATA;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                PAR: begin
                    if (cnt_r == LAST) begin
                        cnt_r    <= '0;
                        par_ok_r <= parity_ok(shift_r, rx_s, PARITY);
                        state_r  <= STOP;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt_r == LAST) begin
                        cnt_r <= '0;
                        if (rx_s == 1'b0) begin
                            // Framing error wins over parity; wait out a held-low line.
                            frame_err_r <= 1'b1;
                            state_r     <= BRK;
                        end else if (par_ok_r) begin
                            data_r  <= shift_r;
                            load_r  <= 1'b1;
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            parity_err_r <= 1'b1;
                            state_r      <= IDLE;
                            busy_r       <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                BRK: begin
                    cnt_r <= '0;
                    if (rx_s == 1'b1) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= BRK;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule
